// File: rtl/alu_issue_stage.sv
// ID->EX issue register with operand select, MEM/WB forwarding, held-operand refresh and load-use bubbles.
// Optional performance counters are enabled by defining ISSUE_PERF_CNT_EN.
package alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_func_t;
endpackage

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               id_valid_i,
    output logic               id_ready_o,
    input  alu_func_t          id_fn_i,
    input  logic [XLEN-1:0]    id_pc_i,
    input  logic [XLEN-1:0]    id_rs1_val_i,
    input  logic [XLEN-1:0]    id_rs2_val_i,
    input  logic [XLEN-1:0]    id_imm_i,
    input  logic [REGBITS-1:0] id_rs1_i,
    input  logic [REGBITS-1:0] id_rs2_i,
    input  logic [REGBITS-1:0] id_rd_i,
    input  logic               id_op1_pc_i,
    input  logic               id_op2_imm_i,
    input  logic               mem_fwd_valid_i,
    input  logic               mem_fwd_load_i,
    input  logic [REGBITS-1:0] mem_fwd_rd_i,
    input  logic [XLEN-1:0]    mem_fwd_data_i,
    input  logic               wb_fwd_valid_i,
    input  logic [REGBITS-1:0] wb_fwd_rd_i,
    input  logic [XLEN-1:0]    wb_fwd_data_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output alu_func_t          ex_fn_o,
    output logic [XLEN-1:0]    ex_in1_o,
    output logic [XLEN-1:0]    ex_in2_o,
    output logic [XLEN-1:0]    ex_rs2_data_o,
    output logic [XLEN-1:0]    ex_pc_o,
    output logic [REGBITS-1:0] ex_rd_o
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_bubble_cnt_o,
    output logic [31:0]        perf_stall_cnt_o
`endif
);

    localparam logic [REGBITS-1:0] X0 = {REGBITS{1'b0}};

    logic                full_q,    full_d;
    alu_func_t           fn_q,      fn_d;
    logic [XLEN-1:0]     pc_q,      pc_d;
    logic [XLEN-1:0]     imm_q,     imm_d;
    logic [XLEN-1:0]     rs1_val_q, rs1_val_d;
    logic [XLEN-1:0]     rs2_val_q, rs2_val_d;
    logic [REGBITS-1:0]  rs1_q,     rs1_d;
    logic [REGBITS-1:0]  rs2_q,     rs2_d;
    logic [REGBITS-1:0]  rd_q,      rd_d;
    logic                op1_pc_q,  op1_pc_d;
    logic                op2_imm_q, op2_imm_d;

    logic                hazard_s;
    logic                capture_s;
    logic                xfer_s;
    logic [XLEN-1:0]     rs1_fwd_s;
    logic [XLEN-1:0]     rs2_fwd_s;

    function automatic logic wb_hit(input logic [REGBITS-1:0] idx,
                                    input logic               wb_valid,
                                    input logic [REGBITS-1:0] wb_rd);
        return wb_valid && (idx != X0) && (idx == wb_rd);
    endfunction

    // Youngest writer wins: MEM (unless a load), then WB, then the held copy.
    function automatic logic [XLEN-1:0] operand(input logic [REGBITS-1:0] idx,
                                                input logic [XLEN-1:0]    held,
                                                input logic               mem_valid,
                                                input logic               mem_load,
                                                input logic [REGBITS-1:0] mem_rd,
                                                input logic [XLEN-1:0]    mem_data,
                                                input logic               wb_valid,
                                                input logic [REGBITS-1:0] wb_rd,
                                                input logic [XLEN-1:0]    wb_data);
        logic [XLEN-1:0] v;
        if (idx == X0) begin
            v = {XLEN{1'b0}};
        end else if (mem_valid && !mem_load && (idx == mem_rd)) begin
            v = mem_data;
        end else if (wb_hit(idx, wb_valid, wb_rd)) begin
            v = wb_data;
        end else begin
            v = held;
        end
        return v;
    endfunction

    // Load-use detection; rs2 is checked even with an immediate because stores need it.
    always_comb begin
        hazard_s = full_q && mem_fwd_valid_i && mem_fwd_load_i && (mem_fwd_rd_i != X0) &&
                   ((!op1_pc_q && (rs1_q == mem_fwd_rd_i)) || (rs2_q == mem_fwd_rd_i));
    end

    // Handshakes and operand selection towards the ALU.
    always_comb begin
        rs1_fwd_s     = operand(rs1_q, rs1_val_q, mem_fwd_valid_i, mem_fwd_load_i, mem_fwd_rd_i,
                                mem_fwd_data_i, wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i);
        rs2_fwd_s     = operand(rs2_q, rs2_val_q, mem_fwd_valid_i, mem_fwd_load_i, mem_fwd_rd_i,
                                mem_fwd_data_i, wb_fwd_valid_i, wb_fwd_rd_i, wb_fwd_data_i);
        ex_valid_o    = full_q && !hazard_s && !flush_i;
        xfer_s        = ex_valid_o && ex_ready_i;
        id_ready_o    = !full_q || xfer_s;
        capture_s     = id_valid_i && id_ready_o;
        ex_fn_o       = fn_q;
        ex_pc_o       = pc_q;
        ex_rd_o       = rd_q;
        ex_in1_o      = op1_pc_q  ? pc_q  : rs1_fwd_s;
        ex_in2_o      = op2_imm_q ? imm_q : rs2_fwd_s;
        ex_rs2_data_o = rs2_fwd_s;
    end

    // Next-state: flush beats capture; a held uop tracks WB so it never keeps a stale value.
    always_comb begin
        full_d    = full_q;
        fn_d      = fn_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        op1_pc_d  = op1_pc_q;
        op2_imm_d = op2_imm_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (capture_s) begin
            full_d    = 1'b1;
            fn_d      = id_fn_i;
            pc_d      = id_pc_i;
            imm_d     = id_imm_i;
            rs1_d     = id_rs1_i;
            rs2_d     = id_rs2_i;
            rd_d      = id_rd_i;
            op1_pc_d  = id_op1_pc_i;
            op2_imm_d = id_op2_imm_i;
            rs1_val_d = wb_hit(id_rs1_i, wb_fwd_valid_i, wb_fwd_rd_i) ? wb_fwd_data_i : id_rs1_val_i;
            rs2_val_d = wb_hit(id_rs2_i, wb_fwd_valid_i, wb_fwd_rd_i) ? wb_fwd_data_i : id_rs2_val_i;
        end else if (xfer_s) begin
            full_d = 1'b0;
        end else if (full_q) begin
            rs1_val_d = wb_hit(rs1_q, wb_fwd_valid_i, wb_fwd_rd_i) ? wb_fwd_data_i : rs1_val_q;
            rs2_val_d = wb_hit(rs2_q, wb_fwd_valid_i, wb_fwd_rd_i) ? wb_fwd_data_i : rs2_val_q;
        end else begin
            full_d = 1'b0;
        end
    end

    // Pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= 1'b0;
            fn_q      <= ALU_ADD;
            pc_q      <= {XLEN{1'b0}};
            imm_q     <= {XLEN{1'b0}};
            rs1_val_q <= {XLEN{1'b0}};
            rs2_val_q <= {XLEN{1'b0}};
            rs1_q     <= X0;
            rs2_q     <= X0;
            rd_q      <= X0;
            op1_pc_q  <= 1'b0;
            op2_imm_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            fn_q      <= fn_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            op1_pc_q  <= op1_pc_d;
            op2_imm_q <= op2_imm_d;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] bubble_q, bubble_d;
    logic [31:0] stall_q,  stall_d;

    // Saturating event counters; untouched by flush.
    always_comb begin
        bubble_d = bubble_q;
        stall_d  = stall_q;
        if (hazard_s && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_d = bubble_q + 32'd1;
        end else begin
            bubble_d = bubble_q;
        end
        if (ex_valid_o && !ex_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q <= 32'd0;
            stall_q  <= 32'd0;
        end else begin
            bubble_q <= bubble_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_bubble_cnt_o = bubble_q;
    assign perf_stall_cnt_o  = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Random-stimulus scoreboard bench for alu_issue_stage: an architectural register file plus a
// MEM->WB writer pipeline define what every operand must be when the uop reaches execute.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        id_valid, id_ready;
    alu_func_t   id_fn;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_op1_pc, id_op2_imm;
    logic        mem_fwd_valid, mem_fwd_load;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        ex_valid, ex_ready;
    alu_func_t   ex_fn;
    logic [31:0] ex_in1, ex_in2, ex_rs2_data, ex_pc;
    logic [4:0]  ex_rd;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt, perf_stall_cnt;
`endif

    alu_issue_stage #(.XLEN(32), .REGBITS(5)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .id_valid_i(id_valid), .id_ready_o(id_ready), .id_fn_i(id_fn), .id_pc_i(id_pc),
        .id_rs1_val_i(id_rs1_val), .id_rs2_val_i(id_rs2_val), .id_imm_i(id_imm),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_op1_pc_i(id_op1_pc), .id_op2_imm_i(id_op2_imm),
        .mem_fwd_valid_i(mem_fwd_valid), .mem_fwd_load_i(mem_fwd_load),
        .mem_fwd_rd_i(mem_fwd_rd), .mem_fwd_data_i(mem_fwd_data),
        .wb_fwd_valid_i(wb_fwd_valid), .wb_fwd_rd_i(wb_fwd_rd), .wb_fwd_data_i(wb_fwd_data),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_fn_o(ex_fn),
        .ex_in1_o(ex_in1), .ex_in2_o(ex_in2), .ex_rs2_data_o(ex_rs2_data),
        .ex_pc_o(ex_pc), .ex_rd_o(ex_rd)
`ifdef ISSUE_PERF_CNT_EN
        , .perf_bubble_cnt_o(perf_bubble_cnt), .perf_stall_cnt_o(perf_stall_cnt)
`endif
    );

    typedef struct {
        alu_func_t   fn;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        op1_pc;
        logic        op2_imm;
    } uop_t;

    uop_t        sbq[$];
    logic [31:0] rf [32];
    logic [31:0] mem_hidden;
    int          n_checks;
    int          n_fail;
    bit          mon_en;

    uop_t        mon_u;
    logic        mon_exp_v;
    logic        mon_hz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural value seen by execute: newest completed older writer, else the register file.
    function automatic logic [31:0] arch_val(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (mem_fwd_valid && !mem_fwd_load && mem_fwd_rd == r) return mem_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd == r) return wb_fwd_data;
        return rf[r];
    endfunction

    function automatic logic load_pending(input logic [4:0] r);
        return (r != 5'd0) && mem_fwd_valid && mem_fwd_load && (mem_fwd_rd == r);
    endfunction

    // Monitor: compares whatever the DUT presents against the queued uop and the register model.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp_v = 1'b0;
            if (sbq.size() > 0) begin
                mon_u     = sbq[0];
                mon_hz    = load_pending(mon_u.op1_pc ? 5'd0 : mon_u.rs1) || load_pending(mon_u.rs2);
                mon_exp_v = !flush && !mon_hz;
            end
            chk("ex_valid", 32'(ex_valid), 32'(mon_exp_v));
            chk("id_ready", 32'(id_ready), 32'((sbq.size() == 0) || (mon_exp_v && ex_ready)));
            if (mon_exp_v && ex_valid) begin
                chk("ex_fn", 32'(ex_fn), 32'(mon_u.fn));
                chk("ex_pc", ex_pc, mon_u.pc);
                chk("ex_rd", 32'(ex_rd), 32'(mon_u.rd));
                chk("ex_in1", ex_in1, mon_u.op1_pc ? mon_u.pc : arch_val(mon_u.rs1));
                chk("ex_in2", ex_in2, mon_u.op2_imm ? mon_u.imm : arch_val(mon_u.rs2));
                chk("ex_rs2_data", ex_rs2_data, arch_val(mon_u.rs2));
            end
            if (mon_exp_v && ex_ready) void'(sbq.pop_front());
            if (flush) sbq.delete();
        end
    end

    // Retire WB into the register file, advance MEM into WB, launch a new MEM writer.
    task automatic cycle_start(input bit quiet);
        @(posedge clk);
        #1;
        if (wb_fwd_valid && wb_fwd_rd != 5'd0) rf[wb_fwd_rd] = wb_fwd_data;
        wb_fwd_valid  = mem_fwd_valid;
        wb_fwd_rd     = mem_fwd_rd;
        wb_fwd_data   = mem_fwd_load ? mem_hidden : mem_fwd_data;
        mem_fwd_valid = !quiet && ($urandom_range(99, 0) < 60);
        mem_fwd_load  = ($urandom_range(99, 0) < 40);
        mem_fwd_rd    = 5'($urandom_range(7, 0));
        mem_fwd_data  = $urandom;
        mem_hidden    = $urandom;
    endtask

    task automatic drive_uop(input logic v, input alu_func_t fn, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic op1, input logic op2);
        id_valid   = v;
        id_fn      = fn;
        id_pc      = pc;
        id_imm     = imm;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_rd      = rd;
        id_op1_pc  = op1;
        id_op2_imm = op2;
        id_rs1_val = rf[rs1];
        id_rs2_val = rf[rs2];
    endtask

    // Record an accepted uop in the scoreboard after the monitor has looked at this cycle.
    task automatic cycle_end();
        uop_t u;
        @(negedge clk);
        #1;
        if (id_valid && id_ready && !flush) begin
            u.fn = id_fn; u.pc = id_pc; u.imm = id_imm;
            u.rs1 = id_rs1; u.rs2 = id_rs2; u.rd = id_rd;
            u.op1_pc = id_op1_pc; u.op2_imm = id_op2_imm;
            sbq.push_back(u);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        flush    = 1'b0;
        ex_ready = 1'b0;
        mem_fwd_valid = 1'b0; mem_fwd_load = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
        wb_fwd_valid  = 1'b1; wb_fwd_rd    = 5'd0; wb_fwd_data  = 32'hFF;
        mem_hidden    = 32'd0;
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        drive_uop(1'b1, ALU_SUB, 32'h44, 32'h9, 5'd3, 5'd4, 5'd2, 1'b0, 1'b0);

        #3;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        chk("rst_ex_fn", 32'(ex_fn), 32'(ALU_ADD));
        chk("rst_ex_in1", ex_in1, 32'd0);
        chk("rst_ex_in2", ex_in2, 32'd0);
        chk("rst_ex_rs2_data", ex_rs2_data, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);

        @(posedge clk);
        #1;
        rst          = 1'b0;
        id_valid     = 1'b0;
        wb_fwd_valid = 1'b0;
        mon_en       = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            cycle_start(1'b0);
            flush    = ($urandom_range(99, 0) < 6);
            ex_ready = ($urandom_range(99, 0) < 65);
            drive_uop($urandom_range(99, 0) < 75, alu_func_t'(4'($urandom_range(9, 0))),
                      $urandom, $urandom, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                      5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            cycle_end();
        end

        // Empty the stage, then park a known uop with execute stalled.
        cycle_start(1'b1);
        flush    = 1'b1;
        ex_ready = 1'b0;
        id_valid = 1'b0;
        cycle_end();
        cycle_start(1'b1);
        flush = 1'b0;
        drive_uop(1'b1, ALU_SUB, 32'h0000_1000, 32'h7, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1);
        cycle_end();
        cycle_start(1'b1);
        id_valid = 1'b0;
        cycle_end();
        chk("hold_ex_valid", 32'(ex_valid), 32'd1);

        // Asynchronous reset in the middle of the hold.
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_hold_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_hold_id_ready", 32'(id_ready), 32'd1);
        chk("rst_hold_ex_fn", 32'(ex_fn), 32'(ALU_ADD));
        chk("rst_hold_ex_pc", ex_pc, 32'd0);
        chk("rst_hold_ex_in1", ex_in1, 32'd0);
        chk("rst_hold_ex_rd", 32'(ex_rd), 32'd0);
        sbq.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
